// File: rtl/activation_memory_controller_pkg.sv
// Shared constants, FSM encoding and helpers for the activation memory controller.
package activation_memory_controller_pkg;

  localparam int unsigned AMC_ADDR_WIDTH = 4;
  localparam int unsigned AMC_DATA_WIDTH = 8;
  localparam int unsigned AMC_BRAM_COUNT = 5;
  localparam int unsigned AMC_IDX_WIDTH  = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PREP  = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Total number of elements the banked memory can hold.
  function automatic int unsigned capacity(input int unsigned bram_count,
                                           input int unsigned addr_width);
    return bram_count * (32'd1 << addr_width);
  endfunction

  localparam int unsigned AMC_CAPACITY = capacity(AMC_BRAM_COUNT, AMC_ADDR_WIDTH);

endpackage

// File: rtl/activation_memory_controller_if.sv
// Activation stream plus the memory-unit side of the controller.
interface activation_memory_controller_if
  import activation_memory_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AMC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AMC_DATA_WIDTH,
  parameter int unsigned BRAM_COUNT = AMC_BRAM_COUNT
);
  localparam int unsigned SEL_WIDTH = BRAM_COUNT - 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [BRAM_COUNT-1:0]            mem_en_bus;
  logic [ADDR_WIDTH-1:0]            mem_w_addr;
  logic [DATA_WIDTH-1:0]            mem_data_in;
  logic [BRAM_COUNT*ADDR_WIDTH-1:0] mem_r_addr;
  logic [SEL_WIDTH*BRAM_COUNT-1:0]  mem_data_out_sels;
  logic                             out_valid;

  // Controller side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_en_bus, mem_w_addr, mem_data_in,
           mem_r_addr, mem_data_out_sels, out_valid
  );

  // Stream producer / memory unit side.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_en_bus, mem_w_addr, mem_data_in,
           mem_r_addr, mem_data_out_sels, out_valid
  );

endinterface

// File: rtl/activation_memory_controller_bank_pointer.sv
// (bank, addr) element pointer; advancing by k wraps the bank and carries into addr.
module activation_memory_controller_bank_pointer
  import activation_memory_controller_pkg::*;
#(
  parameter int unsigned BRAM_COUNT = AMC_BRAM_COUNT,
  parameter int unsigned ADDR_WIDTH = AMC_ADDR_WIDTH,
  parameter int unsigned BANK_W     = clog2(AMC_BRAM_COUNT),
  parameter int unsigned STEP_W     = BANK_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_i,
  input  logic [BANK_W-1:0]     set_bank_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  inc_i,
  input  logic [STEP_W-1:0]     step_i,
  output logic [BANK_W-1:0]     bank_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STEP_W-1:0]     sum_c;

  // Step is at most BRAM_COUNT, so one conditional subtract normalises the bank.
  always_comb begin
    bank_d = bank_q;
    addr_d = addr_q;
    sum_c  = STEP_W'(bank_q) + step_i;
    if (set_i) begin
      bank_d = set_bank_i;
      addr_d = set_addr_i;
    end else if (inc_i) begin
      if (sum_c >= STEP_W'(BRAM_COUNT)) begin
        bank_d = BANK_W'(sum_c - STEP_W'(BRAM_COUNT));
        addr_d = addr_q + ADDR_WIDTH'(1);
      end else begin
        bank_d = BANK_W'(sum_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
    end
  end

  assign bank_o = bank_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/activation_memory_controller.sv
// Sequencer for the banked activation memory: stripes a stream into the banks and
// issues one sliding window of BRAM_COUNT consecutive elements per cycle.
module activation_memory_controller
  import activation_memory_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AMC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = AMC_DATA_WIDTH,
  parameter int unsigned BRAM_COUNT = AMC_BRAM_COUNT,
  parameter int unsigned IDX_WIDTH  = AMC_IDX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start_i,
  input  logic [IDX_WIDTH-1:0]          load_len_i,
  input  logic                          rd_start_i,
  input  logic [IDX_WIDTH-1:0]          rd_base_i,
  input  logic [IDX_WIDTH-1:0]          rd_stride_i,
  input  logic [IDX_WIDTH-1:0]          rd_count_i,
  activation_memory_controller_if.slave bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned SEL_WIDTH = BRAM_COUNT - 1;
  localparam int unsigned BANK_W    = (BRAM_COUNT > 1) ? clog2(BRAM_COUNT) : 1;
  localparam int unsigned STEP_W    = BANK_W + 1;
  localparam int unsigned CAPACITY  = capacity(BRAM_COUNT, ADDR_WIDTH);
  localparam int unsigned CHK_W     = 2 * IDX_WIDTH + 1;

  state_e                          state_q;
  logic [IDX_WIDTH-1:0]            remain_q;
  logic [IDX_WIDTH-1:0]            rem_q;
  logic [ADDR_WIDTH-1:0]           quot_q;
  logic [STEP_W-1:0]               stride_q;
  logic                            done_q;
  logic                            err_q;
  logic                            out_valid_q;
  logic [SEL_WIDTH*BRAM_COUNT-1:0] sels_q;

  logic                            beat_c;
  logic                            load_bad_c;
  logic                            rd_bad_c;
  logic [CHK_W-1:0]                rd_end_c;
  logic                            rd_ptr_set_c;
  logic [BRAM_COUNT*ADDR_WIDTH-1:0] r_addr_c;
  logic [SEL_WIDTH*BRAM_COUNT-1:0] sels_c;
  logic [STEP_W-1:0]               lane_c;

  logic [BANK_W-1:0]               wr_bank;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [BANK_W-1:0]               rd_bank;
  logic [ADDR_WIDTH-1:0]           rd_addr;

  // Command legality, evaluated in a width wide enough that nothing overflows.
  always_comb begin
    rd_end_c   = CHK_W'(rd_base_i)
               + CHK_W'(rd_count_i - IDX_WIDTH'(1)) * CHK_W'(rd_stride_i)
               + CHK_W'(BRAM_COUNT);
    load_bad_c = CHK_W'(load_len_i) > CHK_W'(CAPACITY);
    rd_bad_c   = (rd_stride_i == '0)
              || (CHK_W'(rd_stride_i) > CHK_W'(BRAM_COUNT))
              || (rd_count_i == '0)
              || (rd_end_c > CHK_W'(CAPACITY));
  end

  assign beat_c       = (state_q == ST_LOAD) && bus.in_valid;
  assign rd_ptr_set_c = (state_q == ST_PREP) && (rem_q < IDX_WIDTH'(BRAM_COUNT));

  activation_memory_controller_bank_pointer #(
    .BRAM_COUNT (BRAM_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_W     (BANK_W),
    .STEP_W     (STEP_W)
  ) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      ((state_q == ST_IDLE) && load_start_i),
    .set_bank_i ('0),
    .set_addr_i ('0),
    .inc_i      (beat_c),
    .step_i     (STEP_W'(1)),
    .bank_o     (wr_bank),
    .addr_o     (wr_addr)
  );

  activation_memory_controller_bank_pointer #(
    .BRAM_COUNT (BRAM_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_W     (BANK_W),
    .STEP_W     (STEP_W)
  ) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (rd_ptr_set_c),
    .set_bank_i (BANK_W'(rem_q)),
    .set_addr_i (quot_q),
    .inc_i      (state_q == ST_READ),
    .step_i     (stride_q),
    .bank_o     (rd_bank),
    .addr_o     (rd_addr)
  );

  // Banks below the window's start bank already hold the next row.
  always_comb begin
    r_addr_c = '0;
    sels_c   = '0;
    lane_c   = '0;
    if (state_q == ST_READ) begin
      for (int unsigned b = 0; b < BRAM_COUNT; b++) begin
        r_addr_c[b*ADDR_WIDTH +: ADDR_WIDTH] =
          (BANK_W'(b) >= rd_bank) ? rd_addr : rd_addr + ADDR_WIDTH'(1);
      end
      for (int unsigned j = 0; j < BRAM_COUNT; j++) begin
        lane_c = STEP_W'(rd_bank) + STEP_W'(j);
        if (lane_c >= STEP_W'(BRAM_COUNT)) lane_c = lane_c - STEP_W'(BRAM_COUNT);
        sels_c[j*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(lane_c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      stride_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sels_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      // Selects and valid trail the read address by the RAM latency.
      out_valid_q <= (state_q == ST_READ);
      sels_q      <= sels_c;
      unique case (state_q)
        ST_IDLE: begin
          if (load_start_i) begin
            if (load_bad_c) begin
              err_q <= 1'b1;
            end else if (load_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q  <= ST_LOAD;
              remain_q <= load_len_i;
            end
          end else if (rd_start_i) begin
            if (rd_bad_c) begin
              err_q <= 1'b1;
            end else begin
              state_q  <= ST_PREP;
              remain_q <= rd_count_i;
              rem_q    <= rd_base_i;
              quot_q   <= '0;
              stride_q <= STEP_W'(rd_stride_i);
            end
          end
        end
        ST_LOAD: begin
          if (beat_c) begin
            remain_q <= remain_q - IDX_WIDTH'(1);
            if (remain_q == IDX_WIDTH'(1)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_PREP: begin
          // base div/mod BRAM_COUNT by one subtraction per cycle.
          if (rem_q >= IDX_WIDTH'(BRAM_COUNT)) begin
            rem_q  <= rem_q - IDX_WIDTH'(BRAM_COUNT);
            quot_q <= quot_q + ADDR_WIDTH'(1);
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          remain_q <= remain_q - IDX_WIDTH'(1);
          if (remain_q == IDX_WIDTH'(1)) begin
            state_q <= ST_DRAIN;
            done_q  <= 1'b1;
          end
        end
        ST_DRAIN: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready          = (state_q == ST_LOAD);
  assign bus.mem_en_bus        = beat_c ? (BRAM_COUNT'(1) << wr_bank) : '0;
  assign bus.mem_w_addr        = beat_c ? wr_addr : '0;
  assign bus.mem_data_in       = beat_c ? bus.in_data : '0;
  assign bus.mem_r_addr        = r_addr_c;
  assign bus.mem_data_out_sels = sels_q;
  assign bus.out_valid         = out_valid_q;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_activation_memory_controller.sv
// Randomised scoreboard bench: element-indexed reference memory, banked RAM model behind the DUT.
module tb_activation_memory_controller;
  import activation_memory_controller_pkg::*;

  localparam int unsigned AW  = AMC_ADDR_WIDTH;
  localparam int unsigned DW  = AMC_DATA_WIDTH;
  localparam int unsigned BC  = AMC_BRAM_COUNT;
  localparam int unsigned IW  = AMC_IDX_WIDTH;
  localparam int unsigned SW  = BC - 1;
  localparam int unsigned CAP = BC * (1 << AW);

  typedef struct packed {
    logic [BC-1:0] en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [IW-1:0] load_len = '0;
  logic          rd_start = 1'b0;
  logic [IW-1:0] rd_base = '0;
  logic [IW-1:0] rd_stride = '0;
  logic [IW-1:0] rd_count = '0;
  logic          busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t              wr_q[$];
  logic [BC*DW-1:0] win_q[$];
  logic [DW-1:0]    ref_mem [CAP];
  logic [DW-1:0]    ram [BC][1 << AW];
  logic [DW-1:0]    rd_reg [BC];
  logic [BC*DW-1:0] mon_act, mon_exp;
  int unsigned      mon_sel;
  wr_t              mon_w;

  activation_memory_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_COUNT(BC)) bus ();

  activation_memory_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_COUNT(BC), .IDX_WIDTH(IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start_i (load_start),
    .load_len_i   (load_len),
    .rd_start_i   (rd_start),
    .rd_base_i    (rd_base),
    .rd_stride_i  (rd_stride),
    .rd_count_i   (rd_count),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory unit model: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    for (int b = 0; b < BC; b++) begin
      if (bus.mem_en_bus[b]) ram[b][bus.mem_w_addr] <= bus.mem_data_in;
      rd_reg[b] <= ram[b][bus.mem_r_addr[b*AW +: AW]];
    end
  end

  // Monitor: pops expected writes and windows whenever the DUT presents one.
  always @(negedge clk) begin
    if (bus.mem_en_bus != '0) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", 64'(bus.mem_en_bus), 64'(0));
      end else begin
        mon_w = wr_q.pop_front();
        check("write_beat", 64'({bus.mem_en_bus, bus.mem_w_addr, bus.mem_data_in}), 64'(mon_w));
      end
    end
    if (bus.out_valid) begin
      for (int j = 0; j < BC; j++) begin
        mon_sel = 32'(bus.mem_data_out_sels[j*SW +: SW]);
        mon_act[j*DW +: DW] = (mon_sel < BC) ? rd_reg[mon_sel] : 'x;
      end
      if (win_q.size() == 0) begin
        check("unexpected_window", 64'(bus.out_valid), 64'(0));
      end else begin
        mon_exp = win_q.pop_front();
        check("window_data", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({bus.in_ready, bus.mem_en_bus, bus.mem_w_addr, bus.mem_data_in,
                                bus.out_valid, busy, done, err}), 64'(0));
    check({name, "_r_addr"}, 64'(bus.mem_r_addr), 64'(0));
    check({name, "_sels"}, 64'(bus.mem_data_out_sels), 64'(0));
  endtask

  // bubble_mode: 0 none, 1 alternating 1,0,1..., 2 random
  task automatic do_load(input int len, input bit rand_data, input int bubble_mode, input bit collide);
    int e, guard;
    bit v;
    logic [DW-1:0] d;
    wr_t w;
    load_start = 1'b1;
    load_len   = IW'(len);
    if (collide) begin
      rd_start = 1'b1; rd_base = '0; rd_stride = IW'(1); rd_count = IW'(1);
    end
    tick();
    load_start = 1'b0;
    rd_start   = 1'b0;
    if (len > int'(CAP)) begin
      check("load_err", 64'({err, busy, done}), 64'(3'b100));
      tick();
      check("load_err_clear", 64'({err, busy}), 64'(0));
      return;
    end
    if (len == 0) begin
      check("load_zero_done", 64'({done, busy, err}), 64'(3'b100));
      tick();
      return;
    end
    e = 0;
    guard = 0;
    while (e < len && guard < 4 * int'(CAP)) begin
      case (bubble_mode)
        1:       v = (guard % 2 == 0);
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      d = rand_data ? DW'($urandom) : DW'(e);
      bus.in_valid = v;
      bus.in_data  = d;
      check("in_ready_busy", 64'({bus.in_ready, busy}), 64'(2'b11));
      if (v) begin
        w.en = BC'(1) << (e % BC);
        w.addr = AW'(e / BC);
        w.data = d;
        wr_q.push_back(w);
        ref_mem[e] = d;
        e++;
      end
      tick();
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    check("load_done", 64'({done, busy, err}), 64'(3'b100));
    tick();
    check("load_done_pulse", 64'(done), 64'(0));
    check("load_writes_drained", 64'(wr_q.size()), 64'(0));
  endtask

  task automatic do_read(input int base, input int stride, input int count,
                         input int abort_at, input bit poke);
    bit legal;
    int p, cyc, ov_cnt, first_ov, done_cyc, err_cnt;
    logic [BC*DW-1:0] w;
    legal = (stride >= 1) && (stride <= int'(BC)) && (count >= 1)
         && (base + (count - 1) * stride + int'(BC) <= int'(CAP));
    rd_start  = 1'b1;
    rd_base   = IW'(base);
    rd_stride = IW'(stride);
    rd_count  = IW'(count);
    tick();
    rd_start = 1'b0;
    if (!legal) begin
      check("rd_err", 64'({err, busy, done}), 64'(3'b100));
      tick();
      check("rd_err_clear", 64'({err, busy}), 64'(0));
      return;
    end
    for (int k = 0; k < count; k++) begin
      for (int j = 0; j < int'(BC); j++) w[j*DW +: DW] = ref_mem[base + k * stride + j];
      win_q.push_back(w);
    end
    p = base / int'(BC) + 1;
    cyc = 1; ov_cnt = 0; first_ov = -1; done_cyc = -1; err_cnt = 0;
    while (done_cyc < 0 && cyc <= p + count + 20) begin
      if (bus.out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (done) done_cyc = cyc;
      if (err) err_cnt++;
      if (abort_at > 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("abort_reset");
        win_q.delete();
        tick();
        check("abort_no_done", 64'({done, busy, bus.out_valid}), 64'(0));
        return;
      end
      load_start = poke && (cyc == 2);
      rd_start   = poke && (cyc == 2);
      load_len   = IW'(3);
      if (done_cyc < 0) begin
        tick();
        cyc++;
      end
    end
    load_start = 1'b0;
    rd_start   = 1'b0;
    check("rd_first_valid", 64'(first_ov), 64'(p + 2));
    check("rd_valid_cycles", 64'(ov_cnt), 64'(count));
    check("rd_done_cycle", 64'(done_cyc), 64'(p + count + 1));
    check("rd_no_err", 64'(err_cnt), 64'(0));
    tick();
    check("rd_idle_after", 64'({busy, done, bus.out_valid}), 64'(0));
    check("rd_windows_drained", 64'(win_q.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stride, count, maxbase, base;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < int'(CAP); i++) ref_mem[i] = '0;
    for (int b = 0; b < int'(BC); b++) begin
      rd_reg[b] = '0;
      for (int a = 0; a < (1 << AW); a++) ram[b][a] = '0;
    end
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    do_load(20, 1'b0, 0, 1'b0);
    do_read(3, 5, 2, 0, 1'b0);
    do_read(0, 1, 4, 0, 1'b0);

    do_read(0, 6, 1, 0, 1'b0);
    do_read(78, 1, 1, 0, 1'b0);
    do_read(0, 0, 1, 0, 1'b0);
    do_read(0, 1, 0, 0, 1'b0);
    do_load(81, 1'b0, 0, 1'b0);
    do_load(0, 1'b0, 0, 1'b0);

    do_load(7, 1'b1, 1, 1'b1);
    do_read(0, 2, 2, 0, 1'b1);

    do_load(int'(CAP), 1'b1, 2, 1'b0);
    do_read(60, 3, 4, 16, 1'b0);
    do_read(60, 3, 4, 0, 1'b0);
    do_read(75, 1, 1, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      stride  = int'($urandom_range(1, BC));
      count   = int'($urandom_range(1, 8));
      maxbase = int'(CAP) - int'(BC) - (count - 1) * stride;
      if ($urandom_range(0, 4) == 0) base = maxbase + 1 + int'($urandom_range(0, 3));
      else base = int'($urandom_range(0, maxbase));
      do_read(base, stride, count, 0, 1'(n % 3 == 0));
    end

    check("final_writes_drained", 64'(wr_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
